// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer states, instruction field
// positions and conditional-branch C2 encodings.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd1,
    ST_T4   = 3'd2,
    ST_T5   = 3'd3,
    ST_T6   = 3'd4
  } state_e;

  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int C2_MSB = 20;
  localparam int C2_LSB = 19;
  localparam int C_MSB  = 18;
  localparam int C_LSB  = 0;

  localparam logic [1:0] C2_BRZR = 2'b00;
  localparam logic [1:0] C2_BRNZ = 2'b01;
  localparam logic [1:0] C2_BRPL = 2'b10;
  localparam logic [1:0] C2_BRMI = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  // Next count: advance unless already saturated
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {CNT_W{1'b1}})) begin
      q_d = q_q + CNT_W'(1);
    end else begin
      q_d = q_q;
    end
  end

  // Count register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/branch_sequencer.sv
// Micro-operation sequencer for brzr/brnz/brpl/brmi: evaluates CON, builds
// PC+C and commits it only when the branch is taken.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             hold,
  input  logic             con_out,
  output logic [1:0]       c2bits,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] n_taken,
  output logic [CNT_W-1:0] n_not_taken
);

  state_e     state_q, state_d;
  logic [1:0] c2_q, c2_d;
  logic       taken_q, taken_d;
  logic       inc_taken_s, inc_not_taken_s;

  // Ra and C travel on the datapath, not through this block
  logic unused_ir_fields_s;
  assign unused_ir_fields_s = ^{ir[31:RA_MSB+1], ir[RA_MSB:RA_LSB],
                                ir[RA_LSB-1:C2_MSB+1], ir[C_MSB:C_LSB]};

  // State, condition select and branch decision registers
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      c2_q    <= 2'b00;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c2_q    <= c2_d;
      taken_q <= taken_d;
    end
  end

  // Next state and strobe decode; hold freezes the FSM and masks all strobes
  always_comb begin
    state_d  = state_q;
    c2_d     = c2_q;
    taken_d  = taken_q;
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    taken    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          c2_d    = ir[C2_MSB:C2_LSB];
          state_d = ST_T3;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T3: begin
        busy = 1'b1;
        if (!hold) begin
          gra     = 1'b1;
          r_out   = 1'b1;
          con_in  = 1'b1;
          state_d = ST_T4;
        end else begin
          state_d = ST_T3;
        end
      end
      ST_T4: begin
        busy = 1'b1;
        if (!hold) begin
          pc_out  = 1'b1;
          y_in    = 1'b1;
          taken_d = con_out;
          state_d = ST_T5;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T5: begin
        busy = 1'b1;
        if (!hold) begin
          c_out   = 1'b1;
          alu_add = 1'b1;
          z_in    = 1'b1;
          state_d = ST_T6;
        end else begin
          state_d = ST_T5;
        end
      end
      ST_T6: begin
        busy = 1'b1;
        if (!hold) begin
          done     = 1'b1;
          taken    = taken_q;
          zlow_out = taken_q;
          pc_in    = taken_q;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_T6;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign c2bits          = c2_q;
  assign inc_taken_s     = done & taken_q;
  assign inc_not_taken_s = done & ~taken_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .clear (clear),
    .inc   (inc_taken_s),
    .q     (n_taken)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_not_taken (
    .clk   (clk),
    .clear (clear),
    .inc   (inc_not_taken_s),
    .q     (n_not_taken)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer with a small datapath/CON environment.
module tb_branch_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clear, start, hold, con_out;
  logic [31:0]   ir;
  logic [1:0]    c2bits;
  logic          gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in;
  logic          zlow_out, pc_in, busy, done, taken;
  logic [CW-1:0] n_taken, n_not_taken;

  branch_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .clear(clear), .start(start), .ir(ir), .hold(hold),
    .con_out(con_out), .c2bits(c2bits), .gra(gra), .r_out(r_out),
    .con_in(con_in), .pc_out(pc_out), .y_in(y_in), .c_out(c_out),
    .alu_add(alu_add), .z_in(z_in), .zlow_out(zlow_out), .pc_in(pc_in),
    .busy(busy), .done(done), .taken(taken), .n_taken(n_taken),
    .n_not_taken(n_not_taken)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic cond(input logic [1:0] c2, input logic [31:0] v);
    case (c2)
      C2_BRZR: return (v == 32'd0);
      C2_BRNZ: return (v != 32'd0);
      C2_BRPL: return ~v[31];
      default: return v[31];
    endcase
  endfunction

  function automatic logic [31:0] sext(input logic [18:0] c);
    return {{13{c[18]}}, c};
  endfunction

  // Environment: register file, CON flip-flop, Y/Z/PC registers
  logic [31:0] regs [16];
  logic [31:0] pc_env = 32'h20;
  logic [31:0] y_env  = 32'h0;
  logic [31:0] z_env  = 32'h0;
  logic        con_q  = 1'b0;
  assign con_out = con_q;

  always @(posedge clk) begin
    if (con_in && gra && r_out) con_q <= cond(c2bits, regs[ir[26:23]]);
    if (pc_out && y_in) y_env <= pc_env;
    if (c_out && alu_add && z_in) z_env <= y_env + sext(ir[18:0]) + 32'd1;
    if (zlow_out && pc_in) pc_env <= z_env;
  end

  // Reference model state and scoreboard
  typedef struct {
    logic        tk;
    int unsigned dcyc;
    logic [31:0] pc;
    int          nt;
    int          nnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last;
  logic        pend_post = 1'b0;
  int          con_cnt = 0;
  int          pc_cnt = 0;
  logic [31:0] mpc = 32'h20;
  int          mt = 0;
  int          mnt = 0;

  // Monitor: samples on the falling edge, compares on done and one cycle after
  initial begin
    forever begin
      @(negedge clk);
      if (!clear) begin
        con_cnt = 0;
        pc_cnt  = 0;
      end else begin
        if (con_in) con_cnt++;
        if (pc_in) pc_cnt++;
        if (hold && busy)
          chk("strobes_during_hold",
              {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, done}, 0);
        if (pend_post) begin
          chk("pc_after", pc_env, last.pc);
          chk("n_taken", n_taken, last.nt);
          chk("n_not_taken", n_not_taken, last.nnt);
          pend_post = 1'b0;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            last = exp_q.pop_front();
            chk("taken", taken, last.tk);
            chk("done_cycle", cyc, last.dcyc);
            chk("busy_at_done", busy, 1);
            chk("con_in_pulses", con_cnt, 1);
            chk("pc_in_pulses", pc_cnt, last.tk);
            pend_post = 1'b1;
          end
          con_cnt = 0;
          pc_cnt  = 0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] c2, input logic [3:0] ra, input logic [31:0] rv,
                       input logic [18:0] cv, input int h3, input int h4, input int h5,
                       input int h6, input int gap);
    exp_t e;
    int   hs[4];
    hs = '{h3, h4, h5, h6};
    repeat (gap) begin
      start = 1'b0;
      hold  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    regs[ra] = rv;
    ir = $urandom;
    ir[26:23] = ra;
    ir[20:19] = c2;
    ir[18:0]  = cv;
    e.tk = cond(c2, rv);
    if (e.tk) begin
      mpc = mpc + sext(cv) + 32'd1;
      mt  = (mt == SAT) ? SAT : mt + 1;
    end else begin
      mnt = (mnt == SAT) ? SAT : mnt + 1;
    end
    e.dcyc = cyc + 4 + h3 + h4 + h5 + h6;
    e.pc   = mpc;
    e.nt   = mt;
    e.nnt  = mnt;
    exp_q.push_back(e);
    start = 1'b1;
    hold  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < hs[s]; k++) begin
        hold  = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      hold  = 1'b0;
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pend_post) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (n >= 100), 0);
  endtask

  function automatic int pick_hold();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  logic [31:0] pc_save;
  logic [31:0] rv;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    clear = 1'b0; start = 1'b0; hold = 1'b0; ir = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {c2bits, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, busy, done, taken}, 0);
    chk("reset_counters", {n_taken, n_not_taken}, 0);
    @(posedge clk); #1;
    clear = 1'b1;

    // brzr with Ra=0, C=0x10 from PC=0x20
    issue(C2_BRZR, 4'd1, 32'h0, 19'h10, 0, 0, 0, 0, 0);
    drain();
    chk("z_value", z_env, 32'h31);
    // brnz with Ra=0: not taken
    issue(C2_BRNZ, 4'd2, 32'h0, 19'h7, 0, 0, 0, 0, 1);
    // brmi with Ra negative, three hold cycles in T4
    issue(C2_BRMI, 4'd3, 32'h8000_0000, 19'h4, 0, 3, 0, 0, 0);
    drain();

    // Abort a taken brpl with clear in T5
    regs[5] = 32'h0000_1234;
    ir = 32'h0; ir[26:23] = 4'd5; ir[20:19] = C2_BRPL; ir[18:0] = 19'h40;
    pc_save = pc_env;
    start = 1'b1; hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    chk("abort_outputs",
        {c2bits, gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in, busy, done, taken}, 0);
    chk("abort_counters", {n_taken, n_not_taken}, 0);
    chk("abort_pc", pc_env, pc_save);
    mt = 0; mnt = 0;
    @(posedge clk); #1;

    // Five taken branches saturate the 2-bit counter
    for (int i = 0; i < 5; i++) issue(C2_BRZR, 4'd6, 32'h0, 19'($urandom), 0, 0, 0, 0, 0);
    drain();
    chk("saturated_n_taken", n_taken, 3);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: rv = 32'h0;
        1: rv = 32'h8000_0000 | $urandom;
        2: rv = $urandom & 32'h7fff_ffff;
        default: rv = $urandom;
      endcase
      issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rv, 19'($urandom),
            pick_hold(), pick_hold(), pick_hold(), pick_hold(), int'($urandom_range(0, 2)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control-side sequencer for the conditional-branch (brzr/brnz/brpl/brmi) instruction class of the single-bus datapath. It drives the micro-operations that place Ra on the bus, clocks the CON flip-flop via `con_in`, and reads back its `con_out` flag. It then forms the target PC+C and commits it to PC only when the condition holds. It also keeps saturating taken/not-taken branch counters for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of each branch statistics counter.

Ports:
- `clk`: input, 1 bit. System clock; all state changes on the rising edge.
- `clear`: input, 1 bit. Synchronous, active-low reset.
- `start`: input, 1 bit. One-cycle pulse from the main control unit; a decoded branch instruction is in `ir`.
- `ir`: input, 32 bits. Instruction register. Fields used: Ra = [26:23], C2 = [20:19], C = [18:0].
- `hold`: input, 1 bit. Stall request, e.g. memory busy. Freezes the FSM in its current state.
- `con_out`: input, 1 bit. Registered branch flag returned from the CON flip-flop.
- `c2bits`: output, 2 bits. Condition select to the CON logic: `ir[20:19]`, held stable from T3 through T6.
- `gra`, `r_out`: output, 1 bit each. Select Ra and drive it onto the bus.
- `con_in`: output, 1 bit. Clock/enable pulse to the CON flip-flop.
- `pc_out`, `y_in`: output, 1 bit each. Drive PC onto the bus; load Y.
- `c_out`, `alu_add`, `z_in`: output, 1 bit each. Drive sign-extended C; select ALU add; load Z.
- `zlow_out`, `pc_in`: output, 1 bit each. Drive Zlow onto the bus; load PC.
- `busy`: output, 1 bit. High from T3 through T6 inclusive.
- `done`: output, 1 bit. One-cycle pulse when the sequence completes.
- `taken`: output, 1 bit. Branch decision for the current instruction. Valid while `done` is high.
- `n_taken`, `n_not_taken`: output, `CNT_W` bits each. Saturating statistics counters.

## Operation
- States: IDLE, T3, T4, T5, T6.
- IDLE:
  - All strobes are 0.
  - `start`=1 latches `ir[20:19]` into an internal `c2_q` and moves to T3.
  - `start` is ignored in every state other than IDLE.
- T3: `gra`=1, `r_out`=1, `con_in`=1. Go to T4.
- T4: `pc_out`=1, `y_in`=1. `con_out` is sampled into internal `taken_q`. Go to T5.
- T5: `c_out`=1, `alu_add`=1, `z_in`=1. Go to T6.
- T6:
  - If `taken_q`=1: `zlow_out`=1 and `pc_in`=1.
  - If `taken_q`=0: no strobes.
  - In both cases `done`=1 and `taken`=`taken_q`.
  - Increment `n_taken` or `n_not_taken`. Go to IDLE.
- Counters saturate at 2^CNT_W−1; they never wrap.
- `c2bits` = `c2_q` at all times. Its reset value is 0.
- `hold`=1 in any T-state:
  - The state, `c2_q` and `taken_q` are frozen.
  - All strobes are forced to 0, so `con_in`, `pc_in`, etc. never repeat or extend.
  - `busy` stays 1; `done` stays 0.
  - On `hold` deassertion, the frozen state's strobes are driven for exactly one cycle.
- `hold` in IDLE has no effect; `start` is still accepted.
- All strobe outputs are decoded combinationally from the registered state and `hold`.

## Timing
- Reset (`clear`=0 at a clk edge):
  - State goes to IDLE.
  - `c2_q`=0, `taken_q`=0, `n_taken`=0, `n_not_taken`=0.
  - All strobes, `busy`, `done` and `taken` are 0.
- Reset mid-sequence aborts without a PC write and leaves the counters at 0.
- Latency with no hold: `start` in cycle N gives T3 in N+1 and `done` in N+4.
- Each hold cycle adds one cycle of latency.
- `con_out` must reflect the `con_in` of T3 by T4's sampling edge. The CON flip-flop updates on the `con_in` edge, so its output is one clock after the T3 edge.
- Back-to-back operation: `start` may be asserted in the cycle after `done`, giving T3 two cycles after T6.
- A `start` in the same cycle as `done` is ignored, because the FSM is still in T6.

## Structure
- The shared package `cpu_ctrl_pkg` holds:
  - the state enum (IDLE, T3–T6);
  - the field-position constants for Ra, C2 and C;
  - the C2 encodings: 00 brzr, 01 brnz, 10 brpl, 11 brmi.
- One sub-module, `sat_counter` (parameter `CNT_W`; inputs `clk`, `clear`, `inc`; output `q`), instantiated twice.
- The FSM and strobe decode are kept in the top module.

## Test plan
- brzr, Ra=0 (C2=00, C=0x10, PC=0x20): `pc_in` asserted in T6; Z reads 0x31 (the ALU adds PC+1); `taken`=1; `n_taken`=1.
- brnz, Ra=0 (C2=01): `con_out`=0 at T4, so `pc_in` stays 0 in T6; `taken`=0; `n_not_taken`=1; `done` exactly 4 cycles after `start`.
- brmi, Ra=0x80000000 (C2=11), with `hold`=1 for 3 cycles entered in T4:
  - `con_in` pulses exactly once;
  - `done` is 7 cycles after `start`;
  - branch taken.
- `clear`=0 asserted in T5 of a taken brpl: no `pc_in` ever asserted; next-cycle outputs all 0; state IDLE.
- Counter saturation with `CNT_W`=2: 5 taken branches leave `n_taken`=3.
- `start` held high continuously: sequences run back-to-back with a one-cycle IDLE between them, and `start` during T3–T6 is ignored.
